// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
//   Shift-add multiply / restoring divide on operand magnitudes. A final FIX
//   cycle applies sign correction and writes HI/LO.
// Ports:
//   clk, reset (async, active low)
//   start, op[1:0]          launch request; op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b                    rs / rt operands, sampled only on the launch edge
//   hi_we, lo_we, wd        mthi / mtlo writes, honoured only while idle
//   hi, lo                  HI / LO registers
//   busy, done              operation in progress / one-cycle completion pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic             sa, sb, dz;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] opnd;   // multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0] acc;    // product upper half (MUL) or remainder (DIV)
    logic [WIDTH-1:0] low;    // multiplier shifting out / quotient shifting in

    // Launch magnitudes: abs value only for signed ops. abs(0x80..0) wraps to
    // itself, which read as unsigned is exactly 2^(WIDTH-1).
    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // Multiply step: add into the carry-extended upper half, then shift right.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc} + {1'b0, (low[0] ? opnd : '0)};

    // Divide step: shifted partial remainder is WIDTH+1 bits wide.
    logic [WIDTH:0] sh;
    logic           ge;
    assign sh = {acc, low[WIDTH-1]};
    assign ge = sh >= {1'b0, opnd};

    // Completion values.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod     = {acc, low};
    assign prod_fix = (op_q[0] && (sa ^ sb)) ? -prod : prod;
    assign quot_fix = (op_q[0] && (sa ^ sb)) ? -low : low;
    assign rem_fix  = (op_q[0] && sa) ? -acc : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            a_orig <= '0;
            opnd   <= '0;
            acc    <= '0;
            low    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (start) begin
                        op_q   <= op;
                        sa     <= a[WIDTH-1];
                        sb     <= b[WIDTH-1];
                        dz     <= op[1] && (b == '0);
                        a_orig <= a;
                        cnt    <= '0;
                        acc    <= '0;
                        busy   <= 1'b1;
                        if (op[1]) begin
                            opnd  <= mag_b;
                            low   <= mag_a;
                            state <= DIV;
                        end else begin
                            opnd  <= mag_a;
                            low   <= mag_b;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= sum[WIDTH:1];
                    low <= {sum[0], low[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                DIV: begin
                    // When ge, the difference is below the divisor so fits WIDTH bits.
                    acc <= ge ? (sh[WIDTH-1:0] - opnd) : sh[WIDTH-1:0];
                    low <= {low[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!op_q[1]) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (dz) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference results from 64-bit
// arithmetic are queued at launch and compared when done pulses.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];
    logic [31:0] last_hi = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (o)
            2'b00: p = {32'b0, x} * {32'b0, y};
            2'b01: p = 64'(sx * sy);
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else if (o == 2'b10) p = {x % y, x / y};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Launch one op from a negedge and run it to completion. With inject set,
    // a second start and an mthi write are driven mid-operation.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit inject);
        int n;
        logic [63:0] exp;
        sb_q.push_back(model(o, x, y));
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~o;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: got %b want 0", name, done);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 5) begin start = 1'b1; hi_we = 1'b1; wd = 32'hAAAA; end
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0;
        end
        exp = sb_q.pop_front();
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want 33", name, n);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done: got %b want 1", name, done);
        end
        vectors++;
        if ({hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
        last_hi = exp[63:32];
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #4;
        vectors++;
        if ({hi, lo, busy, done} !== 66'b0) begin
            miscompares++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 0);
        do_op("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mult_negxneg", 2'b01, 32'hFFFF_FFF0, 32'hFFFF_FFF9, 0);
    endtask

    task automatic test_div();
        do_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu_100by7", 2'b10, 32'd100, 32'd7, 0);
        do_op("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("div_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 0);
    endtask

    task automatic test_div_zero();
        do_op("divu_by0", 2'b10, 32'h1234, 32'd0, 0);
        do_op("div_by0", 2'b11, 32'hFFFF_FF00, 32'd0, 0);
    endtask

    task automatic test_busy_ignore();
        do_op("busy_ignore", 2'b00, 32'h0001_2345, 32'h0006_789A, 1);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_nostart: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mtlo();
        lo_we = 1'b1; wd = 32'h55;
        @(negedge clk);
        lo_we = 1'b0;
        vectors++;
        if (lo !== 32'h55 || hi !== last_hi) begin
            miscompares++;
            $display("FAIL mtlo: got hi=%h lo=%h want hi=%h lo=00000055", hi, lo, last_hi);
        end
        hi_we = 1'b1; wd = 32'h7777_0001;
        @(negedge clk);
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h7777_0001 || lo !== 32'h55) begin
            miscompares++;
            $display("FAIL mthi: got hi=%h lo=%h want hi=77770001 lo=00000055", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        op = 2'b00; a = 32'hFFFF_0000; b = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({hi, lo, busy, done} !== 66'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op("after_reset", 2'b00, 32'd123456, 32'd789, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_op("b2b_rand", 2'(i), $urandom, (i == 2) ? 32'($urandom_range(1, 1000)) : $urandom, 0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_mtlo();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
